// File: rtl/xmss_apb3_pkg.sv
// Shared definitions for the XMSS APB3 register bridge: register map,
// CTRL/STATUS bit positions, engine command codes and sequencer states.
package xmss_apb3_pkg;

    // Byte offsets of the register map (address bits [1:0] are ignored)
    localparam logic [7:0] ADDR_DATA_LAST = 8'h7C;
    localparam logic [7:0] ADDR_CMD       = 8'h80;
    localparam logic [7:0] ADDR_CTRL      = 8'h84;
    localparam logic [7:0] ADDR_FLAGS     = 8'h88;
    localparam logic [7:0] ADDR_STEPS     = 8'h8C;
    localparam logic [7:0] ADDR_STATUS    = 8'h90;
    localparam logic [7:0] ADDR_OUT_FIRST = 8'hA0;
    localparam logic [7:0] ADDR_OUT_LAST  = 8'hBC;

    // CTRL write bits
    localparam int CTRL_START         = 0;
    localparam int CTRL_SHA_INIT_MSG  = 1;
    localparam int CTRL_SHA_INIT_IV   = 2;
    localparam int CTRL_XMSS_INIT_IV  = 3;

    // STATUS read bits
    localparam int STATUS_BUSY  = 0;
    localparam int STATUS_DONE  = 1;
    localparam int STATUS_ERROR = 2;

    // FLAGS bits
    localparam int FLAG_SECOND_BLOCK = 0;
    localparam int FLAG_STORE_INT    = 1;
    localparam int FLAG_CONTINUE_INT = 2;
    localparam int FLAG_MSG_LENGTH   = 3;

    // Engine select codes held in CMD
    localparam logic [2:0] CMD_SHA256    = 3'b001;
    localparam logic [2:0] CMD_XMSS      = 3'b010;
    localparam logic [2:0] CMD_GEN_CHAIN = 3'b011;

    // Last count value of the busy-wait window (four cycles: 0..3)
    localparam logic [1:0] WAIT_BUSY_LAST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_e;

    // A start is only meaningful for one of the three engine codes
    function automatic logic cmd_is_valid(input logic [2:0] cmd);
        return (cmd == CMD_SHA256) || (cmd == CMD_XMSS) || (cmd == CMD_GEN_CHAIN);
    endfunction

endpackage

// File: rtl/xmss_apb3_seq.sv
// Launch sequencer: emits the start cycle, waits for the engine to report
// busy (with a short timeout), tracks completion and the sticky done flag.
module xmss_apb3_seq
    import xmss_apb3_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start_accept,
    input  logic status_clear,
    input  logic module_busy,
    input  logic xmss_done,
    input  logic cmd_is_xmss,
    output logic launch,
    output logic seq_busy,
    output logic done
);

    seq_state_e  state_q, state_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;
    logic        done_q, done_d;
    logic        finish;

    // State, timeout counter and done flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic; a finishing run sets done and beats a same-cycle clear
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        finish     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_accept) state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                state_d    = ST_WAIT_BUSY;
                wait_cnt_d = '0;
            end
            ST_WAIT_BUSY: begin
                if (module_busy) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == WAIT_BUSY_LAST) begin
                    state_d = ST_IDLE;
                    finish  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            ST_RUN: begin
                if (!module_busy || (xmss_done && cmd_is_xmss)) begin
                    state_d = ST_IDLE;
                    finish  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        done_d = finish | (done_q & ~(status_clear | start_accept));
    end

    assign launch   = (state_q == ST_LAUNCH);
    assign seq_busy = (state_q != ST_IDLE);
    assign done     = done_q;

endmodule

// File: rtl/xmss_apb3_bridge.sv
// APB3 slave exposing the XMSS hash engines: operand image, command and
// configuration registers, control pulses, status and result window.
module xmss_apb3_bridge
    import xmss_apb3_pkg::*;
#(
    parameter int WOTS_W     = 16,
    parameter int WOTS_LOG_W = $clog2(WOTS_W)
) (
    input  logic                  io_mainClk,
    input  logic                  io_systemReset,
    input  logic [7:0]            io_apb_PADDR,
    input  logic                  io_apb_PSEL,
    input  logic                  io_apb_PENABLE,
    input  logic                  io_apb_PWRITE,
    input  logic [31:0]           io_apb_PWDATA,
    output logic [31:0]           io_apb_PRDATA,
    output logic                  io_apb_PREADY,
    output logic                  io_apb_PSLVERROR,
    output logic [2:0]            cmd_reg,
    output logic [1023:0]         input_data_reg,
    output logic                  gen_chain_start_reg,
    output logic                  sha256XMSS_sha256XMSS_start_reg,
    output logic                  sha256_sha256_start_reg,
    output logic [WOTS_LOG_W-1:0] gen_chain_start_step,
    output logic [WOTS_LOG_W-1:0] gen_chain_end_step,
    output logic                  sha256XMSS_sha256XMSS_second_block_data_available,
    output logic                  sha256XMSS_sha256XMSS_store_intermediate,
    output logic                  sha256XMSS_sha256XMSS_continue_intermediate,
    output logic                  sha256XMSS_sha256XMSS_message_length,
    output logic                  sha256XMSS_sha256XMSS_init_iv,
    output logic                  sha256_sha256_init_message,
    output logic                  sha256_sha256_init_iv,
    input  logic [255:0]          output_data,
    input  logic                  module_busy,
    input  logic                  sha256XMSS_done
);

    logic [31:0]           data_q [32];
    logic [31:0]           data_d [32];
    logic [2:0]            cmd_q, cmd_d;
    logic [3:0]            flags_q, flags_d;
    logic [WOTS_LOG_W-1:0] start_step_q, start_step_d;
    logic [WOTS_LOG_W-1:0] end_step_q, end_step_d;
    logic                  error_q, error_d;
    logic                  init_msg_q, init_msg_d;
    logic                  sha_iv_q, sha_iv_d;
    logic                  xmss_iv_q, xmss_iv_d;

    logic [7:0] addr_w;
    logic [4:0] data_idx;
    logic [2:0] out_idx;
    logic       access, wr_acc, rd_acc;
    logic       sel_data, sel_cmd, sel_ctrl, sel_flags, sel_steps, sel_status, sel_out;
    logic       busy_any, cfg_wr, cfg_wr_ok, ctrl_wr, start_req, start_ok, slverr, status_rd;
    logic       launch, seq_busy, done;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^io_apb_PADDR[1:0];

    assign addr_w   = {io_apb_PADDR[7:2], 2'b00};
    assign data_idx = io_apb_PADDR[6:2];
    assign out_idx  = io_apb_PADDR[4:2];
    assign access   = io_apb_PSEL & io_apb_PENABLE;
    assign wr_acc   = access & io_apb_PWRITE;
    assign rd_acc   = access & ~io_apb_PWRITE;

    assign sel_data   = (addr_w <= ADDR_DATA_LAST);
    assign sel_cmd    = (addr_w == ADDR_CMD);
    assign sel_ctrl   = (addr_w == ADDR_CTRL);
    assign sel_flags  = (addr_w == ADDR_FLAGS);
    assign sel_steps  = (addr_w == ADDR_STEPS);
    assign sel_status = (addr_w == ADDR_STATUS);
    assign sel_out    = (addr_w >= ADDR_OUT_FIRST) && (addr_w <= ADDR_OUT_LAST);

    // Configuration is frozen and starts are refused while anything is running
    assign busy_any  = seq_busy | module_busy;
    assign cfg_wr    = wr_acc & (sel_data | sel_cmd | sel_flags | sel_steps);
    assign cfg_wr_ok = cfg_wr & ~busy_any;
    assign ctrl_wr   = wr_acc & sel_ctrl;
    assign start_req = ctrl_wr & io_apb_PWDATA[CTRL_START];
    assign start_ok  = start_req & ~busy_any & cmd_is_valid(cmd_q);
    assign slverr    = (cfg_wr & busy_any) | (start_req & ~start_ok);
    assign status_rd = rd_acc & sel_status;

    xmss_apb3_seq u_seq (
        .clk          (io_mainClk),
        .rst          (io_systemReset),
        .start_accept (start_ok),
        .status_clear (status_rd),
        .module_busy  (module_busy),
        .xmss_done    (sha256XMSS_done),
        .cmd_is_xmss  (cmd_q == CMD_XMSS),
        .launch       (launch),
        .seq_busy     (seq_busy),
        .done         (done)
    );

    // Register-file updates, sticky error and one-shot init pulses
    always_comb begin
        data_d       = data_q;
        cmd_d        = cmd_q;
        flags_d      = flags_q;
        start_step_d = start_step_q;
        end_step_d   = end_step_q;
        if (cfg_wr_ok) begin
            if (sel_data)  data_d[data_idx] = io_apb_PWDATA;
            if (sel_cmd)   cmd_d = io_apb_PWDATA[2:0];
            if (sel_flags) flags_d = io_apb_PWDATA[3:0];
            if (sel_steps) begin
                start_step_d = io_apb_PWDATA[WOTS_LOG_W-1:0];
                end_step_d   = io_apb_PWDATA[16 +: WOTS_LOG_W];
            end
        end
        error_d    = slverr | (error_q & ~status_rd);
        init_msg_d = ctrl_wr & io_apb_PWDATA[CTRL_SHA_INIT_MSG];
        sha_iv_d   = ctrl_wr & io_apb_PWDATA[CTRL_SHA_INIT_IV];
        xmss_iv_d  = ctrl_wr & io_apb_PWDATA[CTRL_XMSS_INIT_IV];
    end

    // Register storage with synchronous reset
    always_ff @(posedge io_mainClk) begin
        if (io_systemReset) begin
            // NOTE: the operand image is a flop array rather than a RAM, so it is cleared like any register.
            for (int i = 0; i < 32; i++) data_q[i] <= '0;
            cmd_q        <= '0;
            flags_q      <= '0;
            start_step_q <= '0;
            end_step_q   <= '0;
            error_q      <= 1'b0;
            init_msg_q   <= 1'b0;
            sha_iv_q     <= 1'b0;
            xmss_iv_q    <= 1'b0;
        end else begin
            data_q       <= data_d;
            cmd_q        <= cmd_d;
            flags_q      <= flags_d;
            start_step_q <= start_step_d;
            end_step_q   <= end_step_d;
            error_q      <= error_d;
            init_msg_q   <= init_msg_d;
            sha_iv_q     <= sha_iv_d;
            xmss_iv_q    <= xmss_iv_d;
        end
    end

    // Read mux: only drives data during the access phase
    always_comb begin
        io_apb_PRDATA = '0;
        if (access) begin
            if (sel_data) begin
                io_apb_PRDATA = data_q[data_idx];
            end else if (sel_cmd) begin
                io_apb_PRDATA[2:0] = cmd_q;
            end else if (sel_flags) begin
                io_apb_PRDATA[3:0] = flags_q;
            end else if (sel_steps) begin
                io_apb_PRDATA[WOTS_LOG_W-1:0]  = start_step_q;
                io_apb_PRDATA[16 +: WOTS_LOG_W] = end_step_q;
            end else if (sel_status) begin
                io_apb_PRDATA[STATUS_BUSY]  = module_busy;
                io_apb_PRDATA[STATUS_DONE]  = done;
                io_apb_PRDATA[STATUS_ERROR] = error_q;
            end else if (sel_out) begin
                io_apb_PRDATA = output_data[{out_idx, 5'b00000} +: 32];
            end
        end
    end

    for (genvar g = 0; g < 32; g++) begin : g_flat
        assign input_data_reg[32*g +: 32] = data_q[g];
    end

    assign io_apb_PREADY    = 1'b1;
    assign io_apb_PSLVERROR = slverr;
    assign cmd_reg          = cmd_q;

    assign gen_chain_start_step = start_step_q;
    assign gen_chain_end_step   = end_step_q;

    assign sha256XMSS_sha256XMSS_second_block_data_available = flags_q[FLAG_SECOND_BLOCK];
    assign sha256XMSS_sha256XMSS_store_intermediate          = flags_q[FLAG_STORE_INT];
    assign sha256XMSS_sha256XMSS_continue_intermediate       = flags_q[FLAG_CONTINUE_INT];
    assign sha256XMSS_sha256XMSS_message_length              = flags_q[FLAG_MSG_LENGTH];

    // Pulses are forced low while reset is held; the start goes to the selected engine only
    assign gen_chain_start_reg             = launch & (cmd_q == CMD_GEN_CHAIN) & ~io_systemReset;
    assign sha256XMSS_sha256XMSS_start_reg = launch & (cmd_q == CMD_XMSS) & ~io_systemReset;
    assign sha256_sha256_start_reg         = launch & (cmd_q == CMD_SHA256) & ~io_systemReset;
    assign sha256_sha256_init_message      = init_msg_q & ~io_systemReset;
    assign sha256_sha256_init_iv           = sha_iv_q & ~io_systemReset;
    assign sha256XMSS_sha256XMSS_init_iv   = xmss_iv_q & ~io_systemReset;

endmodule

// File: tb/tb_xmss_apb3_bridge.sv
// Self-checking bench for xmss_apb3_bridge: register table, randomized
// register traffic against a behavioural map model, and sequencer scenarios.
module tb_xmss_apb3_bridge;

    localparam int LW = 4;

    logic          io_mainClk = 1'b0;
    logic          io_systemReset = 1'b1;
    logic [7:0]    io_apb_PADDR = '0;
    logic          io_apb_PSEL = 1'b0;
    logic          io_apb_PENABLE = 1'b0;
    logic          io_apb_PWRITE = 1'b0;
    logic [31:0]   io_apb_PWDATA = '0;
    logic [31:0]   io_apb_PRDATA;
    logic          io_apb_PREADY;
    logic          io_apb_PSLVERROR;
    logic [2:0]    cmd_reg;
    logic [1023:0] input_data_reg;
    logic          gen_chain_start_reg, xmss_start, sha_start;
    logic [LW-1:0] start_step, end_step;
    logic          f_second, f_store, f_cont, f_len;
    logic          xmss_init_iv, sha_init_msg, sha_init_iv;
    logic [255:0]  output_data;
    logic          module_busy = 1'b0;
    logic          sha256XMSS_done = 1'b0;

    always #5 io_mainClk = ~io_mainClk;

    xmss_apb3_bridge #(.WOTS_W(16), .WOTS_LOG_W(LW)) dut (
        .io_mainClk(io_mainClk), .io_systemReset(io_systemReset),
        .io_apb_PADDR(io_apb_PADDR), .io_apb_PSEL(io_apb_PSEL),
        .io_apb_PENABLE(io_apb_PENABLE), .io_apb_PWRITE(io_apb_PWRITE),
        .io_apb_PWDATA(io_apb_PWDATA), .io_apb_PRDATA(io_apb_PRDATA),
        .io_apb_PREADY(io_apb_PREADY), .io_apb_PSLVERROR(io_apb_PSLVERROR),
        .cmd_reg(cmd_reg), .input_data_reg(input_data_reg),
        .gen_chain_start_reg(gen_chain_start_reg),
        .sha256XMSS_sha256XMSS_start_reg(xmss_start),
        .sha256_sha256_start_reg(sha_start),
        .gen_chain_start_step(start_step), .gen_chain_end_step(end_step),
        .sha256XMSS_sha256XMSS_second_block_data_available(f_second),
        .sha256XMSS_sha256XMSS_store_intermediate(f_store),
        .sha256XMSS_sha256XMSS_continue_intermediate(f_cont),
        .sha256XMSS_sha256XMSS_message_length(f_len),
        .sha256XMSS_sha256XMSS_init_iv(xmss_init_iv),
        .sha256_sha256_init_message(sha_init_msg),
        .sha256_sha256_init_iv(sha_init_iv),
        .output_data(output_data), .module_busy(module_busy),
        .sha256XMSS_done(sha256XMSS_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model of the register map
    logic [31:0]   m_data [32];
    logic [2:0]    m_cmd;
    logic [3:0]    m_flags;
    logic [LW-1:0] m_start, m_end;

    function automatic logic [31:0] out_word(input int k);
        return 32'hA5A5_0000 + k;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_data[i] = '0;
        m_cmd = '0; m_flags = '0; m_start = '0; m_end = '0;
    endtask

    task automatic model_write(input logic [7:0] addr, input logic [31:0] wd);
        int a;
        a = addr & 8'hFC;
        if (a < 8'h80) m_data[a / 4] = wd;
        else if (a == 8'h80) m_cmd = wd[2:0];
        else if (a == 8'h88) m_flags = wd[3:0];
        else if (a == 8'h8C) begin m_start = wd[LW-1:0]; m_end = wd[16 +: LW]; end
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] addr);
        int a;
        a = addr & 8'hFC;
        if (a < 8'h80) return m_data[a / 4];
        if (a == 8'h80) return 32'(m_cmd);
        if (a == 8'h88) return 32'(m_flags);
        if (a == 8'h8C) return (32'(m_end) << 16) | 32'(m_start);
        if (a >= 8'hA0 && a <= 8'hBC) return out_word((a - 8'hA0) / 4);
        return 32'h0;
    endfunction

    // {gen_chain, xmss start, sha start, sha init_msg, sha init_iv, xmss init_iv}
    function automatic logic [5:0] pulse_vec();
        return {gen_chain_start_reg, xmss_start, sha_start, sha_init_msg, sha_init_iv, xmss_init_iv};
    endfunction

    // One APB3 transfer; returns one cycle after the access, 1ns past the edge
    task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
        @(posedge io_mainClk); #1;
        io_apb_PSEL = 1'b1; io_apb_PENABLE = 1'b0; io_apb_PWRITE = wr;
        io_apb_PADDR = addr; io_apb_PWDATA = wd;
        @(posedge io_mainClk); #1;
        io_apb_PENABLE = 1'b1;
        @(negedge io_mainClk);
        rd = io_apb_PRDATA; err = io_apb_PSLVERROR;
        @(posedge io_mainClk); #1;
        io_apb_PSEL = 1'b0; io_apb_PENABLE = 1'b0; io_apb_PWRITE = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] rd; logic err;
        apb(1'b0, addr, 32'h0, rd, err);
        check(name, rd, exp);
    endtask

    task automatic wr_check(input string name, input logic [7:0] addr, input logic [31:0] wd,
                            input logic exp_err);
        logic [31:0] rd; logic err;
        apb(1'b1, addr, wd, rd, err);
        check({name, "_err"}, err, exp_err);
        if (!exp_err) model_write(addr, wd);
    endtask

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
        string       name;
    } vec_t;

    function automatic vec_t mk(input bit wr, input logic [7:0] a, input logic [31:0] wd,
                                input logic [31:0] er, input string n);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = wd; v.exp_rd = er; v.exp_err = 1'b0; v.name = n;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        logic [31:0] rd;
        logic        err;

        for (int k = 0; k < 8; k++) output_data[32*k +: 32] = out_word(k);
        model_reset();

        // Reset state
        repeat (3) @(posedge io_mainClk);
        #1;
        check("rst_pulses", pulse_vec(), 6'b0);
        check("rst_cmd", cmd_reg, 3'b0);
        check("rst_data", input_data_reg == '0, 1'b1);
        check("rst_pready", io_apb_PREADY, 1'b1);
        io_systemReset = 1'b0;
        rd_check("rst_status", 8'h90, 32'h0);

        // Register map table
        vecs.push_back(mk(1, 8'h00, 32'hDEADBEEF, 0, "wr_data0"));
        vecs.push_back(mk(1, 8'h7C, 32'h01234567, 0, "wr_data31"));
        vecs.push_back(mk(0, 8'h00, 0, 32'hDEADBEEF, "rd_data0"));
        vecs.push_back(mk(0, 8'h7C, 0, 32'h01234567, "rd_data31"));
        vecs.push_back(mk(1, 8'h07, 32'hCAFEF00D, 0, "wr_data1_lowbits"));
        vecs.push_back(mk(0, 8'h05, 0, 32'hCAFEF00D, "rd_data1_lowbits"));
        vecs.push_back(mk(1, 8'h80, 32'hFFFFFFFB, 0, "wr_cmd"));
        vecs.push_back(mk(0, 8'h80, 0, 32'h00000003, "rd_cmd"));
        vecs.push_back(mk(1, 8'h88, 32'hFFFFFFF5, 0, "wr_flags"));
        vecs.push_back(mk(0, 8'h88, 0, 32'h00000005, "rd_flags"));
        vecs.push_back(mk(1, 8'h8C, 32'hFFFFFFFF, 0, "wr_steps_all"));
        vecs.push_back(mk(0, 8'h8C, 0, 32'h000F000F, "rd_steps_all"));
        vecs.push_back(mk(1, 8'h8C, 32'h000F0002, 0, "wr_steps"));
        vecs.push_back(mk(0, 8'h8C, 0, 32'h000F0002, "rd_steps"));
        vecs.push_back(mk(1, 8'h84, 32'h00000000, 0, "wr_ctrl_zero"));
        vecs.push_back(mk(0, 8'h84, 0, 32'h0, "rd_ctrl"));
        vecs.push_back(mk(1, 8'hC0, 32'h12345678, 0, "wr_unmapped"));
        vecs.push_back(mk(0, 8'hC0, 0, 32'h0, "rd_unmapped_c0"));
        vecs.push_back(mk(0, 8'h98, 0, 32'h0, "rd_unmapped_98"));
        vecs.push_back(mk(0, 8'hA0, 0, 32'hA5A50000, "rd_out0"));
        vecs.push_back(mk(0, 8'hAC, 0, 32'hA5A50003, "rd_out3"));
        vecs.push_back(mk(0, 8'hBC, 0, 32'hA5A50007, "rd_out7"));
        vecs.push_back(mk(0, 8'h90, 0, 32'h0, "rd_status_idle"));
        for (int i = 0; i < vecs.size(); i++) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err);
            check({vecs[i].name, "_err"}, err, vecs[i].exp_err);
            if (vecs[i].wr) model_write(vecs[i].addr, vecs[i].wdata);
            else check(vecs[i].name, rd, vecs[i].exp_rd);
        end
        check("img_word0", input_data_reg[31:0], 32'hDEADBEEF);
        check("img_word31", input_data_reg[1023:992], 32'h01234567);
        check("cmd_out", cmd_reg, 3'b011);
        check("steps_out", {end_step, start_step}, {4'd15, 4'd2});
        check("flags_out", {f_len, f_cont, f_store, f_second}, 4'b0101);

        // Write held in setup phase only must not land
        @(posedge io_mainClk); #1;
        io_apb_PSEL = 1'b1; io_apb_PWRITE = 1'b1; io_apb_PADDR = 8'h08; io_apb_PWDATA = 32'hBAD0BAD0;
        @(posedge io_mainClk); #1;
        io_apb_PSEL = 1'b0; io_apb_PWRITE = 1'b0;
        check("setup_only_write", input_data_reg[95:64], m_data[2]);

        // Init pulses without start: one cycle each
        wr_check("ctrl_init", 8'h84, 32'hE, 1'b0);
        check("init_pulses", pulse_vec(), 6'b000111);
        @(posedge io_mainClk); #1;
        check("init_pulses_end", pulse_vec(), 6'b0);

        // gen_chain start routed by CMD=011
        wr_check("gc_start", 8'h84, 32'h1, 1'b0);
        check("gc_pulse", pulse_vec(), 6'b100000);
        @(posedge io_mainClk); #1;
        check("gc_pulse_end", pulse_vec(), 6'b0);
        repeat (6) @(posedge io_mainClk);
        rd_check("gc_timeout_done", 8'h90, 32'h2);
        rd_check("gc_done_cleared", 8'h90, 32'h0);

        // Randomized register traffic, engine idle
        for (int n = 0; n < 200; n++) begin
            logic [7:0]  a;
            logic [31:0] wd;
            logic        wr;
            int          u;
            u = $urandom_range(0, 9);
            if (u < 5) a = 8'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            else if (u == 5) a = 8'h80;
            else if (u == 6) a = 8'h88;
            else if (u == 7) a = 8'h8C;
            else if (u == 8) a = 8'(8'hA0 + $urandom_range(0, 7) * 4);
            else begin
                u = $urandom_range(0, 18);
                a = (u < 3) ? 8'(8'h94 + 4 * u) : 8'(8'hC0 + 4 * (u - 3));
            end
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            apb(wr, a, wd, rd, err);
            check($sformatf("rand%0d_err", n), err, 1'b0);
            if (wr) model_write(a, wd);
            else check($sformatf("rand%0d_rd_%02h", n, a), rd, model_read(a));
        end
        for (int w = 0; w < 32; w++)
            check($sformatf("rand_img%0d", w), input_data_reg[32*w +: 32], m_data[w]);
        check("rand_cmd", cmd_reg, m_cmd);
        check("rand_steps", {end_step, start_step}, {m_end, m_start});
        check("rand_flags", {f_len, f_cont, f_store, f_second}, m_flags);

        // sha256 start, busy never rises: done visible exactly 5 cycles after the pulse
        wr_check("sha_cmd", 8'h80, 32'h1, 1'b0);
        wr_check("sha_start", 8'h84, 32'h1, 1'b0);
        check("sha_pulse", pulse_vec(), 6'b001000);
        io_apb_PSEL = 1'b1; io_apb_PENABLE = 1'b1; io_apb_PWRITE = 1'b0; io_apb_PADDR = 8'h90;
        for (int k = 0; k <= 5; k++) begin
            @(negedge io_mainClk);
            check($sformatf("timeout_poll%0d", k), io_apb_PRDATA, (k == 5) ? 32'h2 : 32'h0);
            if (k < 5) begin @(posedge io_mainClk); #1; end
        end
        @(posedge io_mainClk); #1;
        io_apb_PSEL = 1'b0; io_apb_PENABLE = 1'b0;
        rd_check("timeout_cleared", 8'h90, 32'h0);

        // Busy engine: writes refused, init pulses still issued, done on busy fall
        wr_check("busy_start", 8'h84, 32'h1, 1'b0);
        check("busy_pulse", pulse_vec(), 6'b001000);
        module_busy = 1'b1;
        rd_check("busy_status", 8'h90, 32'h1);
        wr_check("busy_wr_data5", 8'h14, 32'h55555555, 1'b1);
        check("busy_data5_kept", input_data_reg[191:160], m_data[5]);
        wr_check("busy_ctrl", 8'h84, 32'hF, 1'b1);
        check("busy_ctrl_pulses", pulse_vec(), 6'b000111);
        rd_check("busy_status_err", 8'h90, 32'h5);
        module_busy = 1'b0;
        rd_check("fall_status_done", 8'h90, 32'h2);
        rd_check("fall_status_clear", 8'h90, 32'h0);
        rd_check("busy_data5_readback", 8'h14, m_data[5]);

        // sha256XMSS done ends the run while busy is still high
        wr_check("xmss_cmd", 8'h80, 32'h2, 1'b0);
        wr_check("xmss_start", 8'h84, 32'h1, 1'b0);
        check("xmss_pulse", pulse_vec(), 6'b010000);
        module_busy = 1'b1;
        repeat (2) @(posedge io_mainClk);
        #1; sha256XMSS_done = 1'b1;
        @(posedge io_mainClk); #1; sha256XMSS_done = 1'b0;
        rd_check("xmss_done_status", 8'h90, 32'h3);
        module_busy = 1'b0;
        rd_check("xmss_done_cleared", 8'h90, 32'h0);

        // Reset in RUN aborts the sequencer and clears everything
        wr_check("rst_cmd_wr", 8'h80, 32'h3, 1'b0);
        wr_check("rst_run_start", 8'h84, 32'h1, 1'b0);
        module_busy = 1'b1;
        repeat (3) @(posedge io_mainClk);
        #1; io_systemReset = 1'b1; module_busy = 1'b0;
        @(posedge io_mainClk); #1;
        check("rstrun_pulses", pulse_vec(), 6'b0);
        check("rstrun_cmd", cmd_reg, 3'b0);
        check("rstrun_data", input_data_reg == '0, 1'b1);
        check("rstrun_cfg", {f_len, f_cont, f_store, f_second, end_step, start_step}, 12'h0);
        check("rstrun_bus", {io_apb_PRDATA, io_apb_PSLVERROR}, 33'h0);
        io_systemReset = 1'b0;
        model_reset();
        @(posedge io_mainClk); #1;
        check("rstrun_no_pulse", pulse_vec(), 6'b0);
        rd_check("rstrun_status", 8'h90, 32'h0);
        rd_check("rstrun_data0", 8'h00, 32'h0);

        // Start with an invalid CMD is refused and flags error
        wr_check("bad_cmd0_start", 8'h84, 32'h1, 1'b1);
        check("bad_cmd0_pulses", pulse_vec(), 6'b0);
        wr_check("bad_cmd4_wr", 8'h80, 32'h4, 1'b0);
        wr_check("bad_cmd4_start", 8'h84, 32'h3, 1'b1);
        check("bad_cmd4_pulses", pulse_vec(), 6'b000100);
        rd_check("bad_cmd_status", 8'h90, 32'h4);
        rd_check("bad_cmd_cleared", 8'h90, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xmss_apb3_bridge.md
XMSS_APB3_BRIDGE -- requirements
Module: xmss_apb3_bridge

Interface
REQ-001 Parameter WOTS_W, default 16: Winternitz parameter.
REQ-002 Parameter WOTS_LOG_W, default `CLOG2(WOTS_W): step field width.
REQ-003 io_mainClk  in  1  sole clock; all logic rising-edge.
REQ-004 io_systemReset  in  1  synchronous, active-high reset.
REQ-005 io_apb_PADDR  in  8  byte address; bits [1:0] ignored.
REQ-006 io_apb_PSEL  in  1 / io_apb_PENABLE  in  1 / io_apb_PWRITE  in  1: APB3 control.
REQ-007 io_apb_PWDATA  in  32 / io_apb_PRDATA  out  32: APB3 data.
REQ-008 io_apb_PREADY  out  1, constant 1 / io_apb_PSLVERROR  out  1.
REQ-009 cmd_reg  out  3  selects engine: 001 sha256, 010 sha256XMSS, 011 gen_chain.
REQ-010 input_data_reg  out  1024  operand image; word i = bits [32i+31:32i].
REQ-011 gen_chain_start_reg, sha256XMSS_sha256XMSS_start_reg, sha256_sha256_start_reg  out  1 each  start pulses.
REQ-012 gen_chain_start_step, gen_chain_end_step  out  WOTS_LOG_W each.
REQ-013 sha256XMSS_sha256XMSS_{second_block_data_available, store_intermediate, continue_intermediate, message_length}  out  1 each  levels.
REQ-014 sha256XMSS_sha256XMSS_init_iv, sha256_sha256_init_message, sha256_sha256_init_iv  out  1 each  pulses.
REQ-015 output_data  in  256 / module_busy  in  1 / sha256XMSS_done  in  1: engine results.

Function
REQ-016 Access completes when PSEL&PENABLE; PREADY=1 always (zero wait); PRDATA combinational from PADDR in access phase, 0 otherwise.
REQ-017 Map: 0x00-0x7C DATA[0..31] RW; 0x80 CMD [2:0] RW; 0x84 CTRL WO (reads 0); 0x88 FLAGS [3:0] RW (second_block, store_int, continue_int, message_length); 0x8C STEPS RW (start_step [WOTS_LOG_W-1:0], end_step [16+WOTS_LOG_W-1:16]); 0x90 STATUS RO (bit0 module_busy, bit1 done, bit2 error); 0xA0-0xBC OUT[0..7] RO = output_data[32k+31:32k]; others read 0.
REQ-018 CTRL write: bit0 start, bit1 sha256 init_message, bit2 sha256 init_iv, bit3 xmss init_iv; each set bit yields exactly one-cycle high on its output in the cycle after the access.
REQ-019 Start pulse routed only to start output selected by current CMD; CMD values 000,1xx: start ignored, PSLVERROR=1, STATUS.error set.
REQ-020 Sequencer FSM IDLE->LAUNCH (pulse cycle)->WAIT_BUSY->RUN->IDLE; sequencer busy = state!=IDLE.
REQ-021 WAIT_BUSY: module_busy=1 -> RUN; 4 cycles without busy -> IDLE with done set.
REQ-022 RUN: module_busy falling, or sha256XMSS_done=1 while CMD=010 -> IDLE, done set.
REQ-023 While sequencer busy or module_busy: writes to DATA/CMD/FLAGS/STEPS and CTRL start are discarded, PSLVERROR=1 for that access, STATUS.error set; CTRL init pulses still issued.
REQ-024 STATUS read clears done and error the cycle after access; set event in same cycle as clear wins (stays set).
REQ-025 Accepted start clears done.
REQ-026 Unmapped write: no state change, PSLVERROR=0.
REQ-027 Write with no PENABLE (setup phase) has no effect.

Reset
REQ-028 All registers, DATA, CMD, FLAGS, STEPS, done, error, FSM=IDLE cleared to 0 in cycle io_systemReset=1; all pulse outputs 0.
REQ-029 Reset mid-operation aborts sequencer to IDLE; no pulse emitted the following cycle.

Structure
REQ-030 Register offsets, CTRL/STATUS bit indices, FSM state encoding in shared package xmss_apb3_pkg.
REQ-031 Sub-module xmss_apb3_seq holds the FSM and done/timeout logic; top holds decode and storage.

Verification
REQ-032 Write DATA[0]=0xDEADBEEF, DATA[31]=0x01234567 -> input_data_reg[31:0]=0xDEADBEEF, [1023:992]=0x01234567; readback matches.
REQ-033 CMD=011, STEPS=0x000F0002, CTRL=1 -> gen_chain_start_reg high one cycle, others 0; start_step=2, end_step=15.
REQ-034 Busy held 10 cycles after start -> STATUS=0x1 during, 0x2 after fall; second STATUS read =0x0.
REQ-035 Write DATA[5] while module_busy=1 -> PSLVERROR=1, DATA[5] unchanged, STATUS.error=1.
REQ-036 CMD=001, start, busy never rises -> done set exactly 5 cycles after pulse.
REQ-037 Reset asserted in RUN -> next cycle all outputs 0, STATUS=0, no start pulse.
